rv32im_lsu: RTL and testbench
=============================

Name: rv32im_lsu

Overview:
Load/store unit directly upstream of the rv32im_memory Wishbone master stage. It accepts one load or store from execute and drives the memory stage's request interface, handling the byte-lane work the memory stage does not do:
- positions store data onto the correct byte lanes;
- extracts, sign-extends or zero-extends load data;
- splits misaligned accesses into sequential byte accesses.

It returns a single completion pulse with the result or an error indication.

Parameters:
XLEN, 32, data/address width (only 32 supported)
ALLOW_MISALIGNED, 1, 1: split misaligned accesses into byte accesses; 0: fault them with no bus traffic

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
flush_i  input  1  pipeline flush; aborts any access in flight
req_i  input  1  request valid; sampled only while busy_o=0
write_i  input  1  1=store, 0=load
funct3_i  input  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr_i  input  XLEN  byte address
wdata_i  input  XLEN  store data, right-aligned
busy_o  output  1  access in progress
done_o  output  1  one-cycle completion pulse
rdata_o  output  XLEN  extended load result; valid with done_o
misaligned_o  output  1  with done_o: misaligned fault (ALLOW_MISALIGNED=0)
err_o  output  1  with done_o: bus error or illegal funct3
mem_data_ready_o  output  1  request strobe to memory stage
mem_clear_o  output  1  clear to memory stage
mem_addr_o  output  XLEN  address to memory stage
mem_word_size_o  output  2  00 byte, 01 half, 10 word
mem_write_o  output  1  write enable to memory stage
mem_data_o  output  XLEN  lane-positioned store data
mem_data_i  input  XLEN  raw 32-bit word returned by memory stage
mem_busy_i  input  1  memory stage busy
mem_err_i  input  1  memory stage sticky error

Behaviour:
- Reset (rst_ni low, asynchronous):
  - state IDLE;
  - all outputs 0, including rdata_o and the mem_* outputs.
- Outputs: all registered.
- States:
  - IDLE: busy_o=0.
    - req_i=1 with illegal funct3 (011, 110, 111, or store with funct3[2]=1): next cycle done_o=1, err_o=1, no bus access.
    - Misaligned access (H with addr[0]=1; W with addr[1:0]!=0) and ALLOW_MISALIGNED=0: next cycle done_o=1, misaligned_o=1, no bus access.
    - Otherwise: latch request, busy_o<=1, go to ISSUE. Aligned accesses use a single access; misaligned accesses use N byte accesses (N=2 for H, 4 for W), byte index k=0..N-1.
  - ISSUE: mem_data_ready_o=1 for exactly one cycle with mem_addr_o/mem_word_size_o/mem_write_o/mem_data_o valid. Go to ARMED.
  - ARMED: wait for mem_busy_i=1, then go to WAIT.
  - WAIT: on mem_busy_i=0:
    - if mem_err_i=1: done_o=1, err_o=1, mem_clear_o pulsed for one cycle, go to IDLE;
    - else capture data; if more byte accesses remain, go to ISSUE (k+1); else done_o=1 with rdata_o, go to IDLE.
- Aligned access:
  - mem_addr_o = addr_i; mem_word_size_o = funct3[1:0].
  - mem_data_o = wdata_i << 8*addr[1:0].
  - load result = mem_data_i >> 8*addr[1:0].
- Split access, byte k:
  - mem_addr_o = addr+k (wraps at 2^32); mem_word_size_o = 00.
  - mem_data_o = wdata[8k+7:8k] << 8*(addr+k)[1:0].
  - Returned lane (addr+k)[1:0] goes into assembly buffer bits [8k+7:8k].
- Extension: B/H sign-extend from bit 7/15; BU/HU zero-extend; W unchanged.
- Stores: rdata_o=0.
- Latency:
  - With a zero-wait-state slave, done_o is high 3 edges after the accepting edge.
  - Each additional byte access adds 3 cycles.
  - Faulted requests take 1 cycle.
- busy_o deasserts in the same cycle done_o asserts.
  - A new req_i may be accepted on the edge where done_o is high.
- flush_i (highest priority after reset):
  - state<=IDLE, busy_o<=0, no done_o;
  - mem_clear_o pulsed for one cycle if state was not IDLE;
  - a req_i in the same cycle is ignored.
- A completed access with an error does not update rdata_o.

Test Plan:
- LB, addr 0x103; slave returns 0x80FF_1234 -> one byte access, mem_word_size_o=00; rdata_o=0xFFFF_FF80 at edge 3; LBU same -> 0x0000_0080.
- SH, addr 0x102, wdata 0x0000_ABCD -> mem_data_o=0xABCD_0000, mem_word_size_o=01, done_o after 3 edges, err_o=0.
- LW, addr 0x101, ALLOW_MISALIGNED=1; memory bytes 0x101..0x104 = 11,22,33,44 -> four byte accesses at 0x101..0x104, rdata_o=0x4433_2211, done_o at edge 12.
- SW, addr 0x102, ALLOW_MISALIGNED=0 -> done_o next cycle, misaligned_o=1, mem_data_ready_o never asserted.
- LW, addr 0x200; slave asserts err_i -> done_o with err_o=1, mem_clear_o pulses once, rdata_o unchanged.
- flush_i asserted in ARMED of an LW -> IDLE, mem_clear_o one pulse, no done_o; next LW completes normally.

Source files
------------

// File: rtl/rv32im_lsu.sv
`default_nettype none
// ============================================================================
// Module      : rv32im_lsu
// Description : Load/store unit in front of the Wishbone memory stage. It
//               places store bytes on their lanes, extends load data and
//               splits misaligned accesses into byte accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32im_lsu #(
    parameter int XLEN             = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            req_i,
    input  logic            write_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            misaligned_o,
    output logic            err_o,
    output logic            mem_data_ready_o,
    output logic            mem_clear_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [1:0]      mem_word_size_o,
    output logic            mem_write_o,
    output logic [XLEN-1:0] mem_data_o,
    input  logic [XLEN-1:0] mem_data_i,
    input  logic            mem_busy_i,
    input  logic            mem_err_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_ARMED = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t          r_state, w_state;
    logic            r_write, w_write;
    logic [2:0]      r_funct3, w_funct3;
    logic [XLEN-1:0] r_addr, w_addr;
    logic [XLEN-1:0] r_wdata, w_wdata;
    logic [XLEN-1:0] r_buf, w_buf;
    logic            r_split, w_split;
    logic [1:0]      r_k, w_k;
    logic [1:0]      r_last_k, w_last_k;

    logic            w_done, w_err, w_mis, w_clear, w_ready, w_issue;
    logic [XLEN-1:0] w_rdata, w_mem_addr, w_mem_data, w_iss_addr;
    logic [1:0]      w_mem_size;
    logic            w_mem_write;

    logic            w_illegal, w_req_mis;
    logic [1:0]      w_cur_lane;
    logic [XLEN-1:0] w_lane, w_asm, w_ext;

    assign w_illegal = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11) ||
                       (write_i && funct3_i[2]);
    assign w_req_mis = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                       ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));

    // Lane of the access now completing; r_k stays 0 for aligned accesses.
    assign w_cur_lane = r_addr[1:0] + r_k;
    assign w_lane     = mem_data_i >> {w_cur_lane, 3'b000};
    assign w_asm      = r_split ? (r_buf | (XLEN'(w_lane[7:0]) << {r_k, 3'b000}))
                                : w_lane;

    always_comb begin
        case (r_funct3)
            3'b000:  w_ext = {{(XLEN-8){w_asm[7]}}, w_asm[7:0]};
            3'b001:  w_ext = {{(XLEN-16){w_asm[15]}}, w_asm[15:0]};
            3'b100:  w_ext = {{(XLEN-8){1'b0}}, w_asm[7:0]};
            3'b101:  w_ext = {{(XLEN-16){1'b0}}, w_asm[15:0]};
            default: w_ext = w_asm;
        endcase
    end

    always_comb begin
        w_state     = r_state;
        w_write     = r_write;
        w_funct3    = r_funct3;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_buf       = r_buf;
        w_split     = r_split;
        w_k         = r_k;
        w_last_k    = r_last_k;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_mis       = 1'b0;
        w_clear     = 1'b0;
        w_ready     = 1'b0;
        w_issue     = 1'b0;
        w_rdata     = rdata_o;
        w_mem_addr  = mem_addr_o;
        w_mem_size  = mem_word_size_o;
        w_mem_write = mem_write_o;
        w_mem_data  = mem_data_o;

        case (r_state)
            S_IDLE: begin
                if (req_i) begin
                    if (w_illegal) begin
                        w_done = 1'b1;
                        w_err  = 1'b1;
                    end else if (w_req_mis && !ALLOW_MISALIGNED) begin
                        w_done = 1'b1;
                        w_mis  = 1'b1;
                    end else begin
                        w_write  = write_i;
                        w_funct3 = funct3_i;
                        w_addr   = addr_i;
                        w_wdata  = wdata_i;
                        w_split  = w_req_mis;
                        w_last_k = funct3_i[1] ? 2'd3 : 2'd1;
                        w_k      = 2'd0;
                        w_buf    = '0;
                        w_issue  = 1'b1;
                        w_state  = S_ISSUE;
                    end
                end
            end
            S_ISSUE: w_state = S_ARMED;
            S_ARMED: begin
                if (mem_busy_i) begin
                    w_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!mem_busy_i) begin
                    if (mem_err_i) begin
                        w_done  = 1'b1;
                        w_err   = 1'b1;
                        w_clear = 1'b1;
                        w_state = S_IDLE;
                    end else begin
                        w_buf = w_asm;
                        if (r_split && (r_k != r_last_k)) begin
                            w_k     = r_k + 2'd1;
                            w_issue = 1'b1;
                            w_state = S_ISSUE;
                        end else begin
                            w_done  = 1'b1;
                            w_rdata = r_write ? '0 : w_ext;
                            w_state = S_IDLE;
                        end
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase

        if (flush_i) begin
            w_state = S_IDLE;
            w_done  = 1'b0;
            w_err   = 1'b0;
            w_mis   = 1'b0;
            w_issue = 1'b0;
            w_rdata = rdata_o;
            w_clear = (r_state != S_IDLE);
        end

        // Drive the memory request from the values the access will carry.
        w_iss_addr = w_addr + XLEN'(w_k);
        if (w_issue) begin
            w_ready     = 1'b1;
            w_mem_write = w_write;
            if (w_split) begin
                w_mem_addr = w_iss_addr;
                w_mem_size = 2'b00;
                w_mem_data = XLEN'(w_wdata[{w_k, 3'b000} +: 8]) << {w_iss_addr[1:0], 3'b000};
            end else begin
                w_mem_addr = w_addr;
                w_mem_size = w_funct3[1:0];
                w_mem_data = w_wdata << {w_addr[1:0], 3'b000};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state          <= S_IDLE;
            r_write          <= 1'b0;
            r_funct3         <= 3'b000;
            r_addr           <= '0;
            r_wdata          <= '0;
            r_buf            <= '0;
            r_split          <= 1'b0;
            r_k              <= 2'd0;
            r_last_k         <= 2'd0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            rdata_o          <= '0;
            misaligned_o     <= 1'b0;
            err_o            <= 1'b0;
            mem_data_ready_o <= 1'b0;
            mem_clear_o      <= 1'b0;
            mem_addr_o       <= '0;
            mem_word_size_o  <= 2'b00;
            mem_write_o      <= 1'b0;
            mem_data_o       <= '0;
        end else begin
            r_state          <= w_state;
            r_write          <= w_write;
            r_funct3         <= w_funct3;
            r_addr           <= w_addr;
            r_wdata          <= w_wdata;
            r_buf            <= w_buf;
            r_split          <= w_split;
            r_k              <= w_k;
            r_last_k         <= w_last_k;
            busy_o           <= (w_state != S_IDLE);
            done_o           <= w_done;
            rdata_o          <= w_rdata;
            misaligned_o     <= w_mis;
            err_o            <= w_err;
            mem_data_ready_o <= w_ready;
            mem_clear_o      <= w_clear;
            mem_addr_o       <= w_mem_addr;
            mem_word_size_o  <= w_mem_size;
            mem_write_o      <= w_mem_write;
            mem_data_o       <= w_mem_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv32im_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32im_lsu
// Description : Directed bench for rv32im_lsu with a zero-wait memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32im_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        req = 1'b0;
    logic        req_nm = 1'b0;
    logic        wr = 1'b0;
    logic [2:0]  f3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;

    logic        busy, done, mis, err, rdy, clr, mwr;
    logic [31:0] rdata, maddr, mdata;
    logic [1:0]  msize;
    logic [31:0] mem_rdata = '0;
    logic        mem_busy = 1'b0;
    logic        mem_err = 1'b0;

    logic        nm_busy, nm_done, nm_mis, nm_err, nm_rdy, nm_clr, nm_mwr;
    logic [31:0] nm_rdata, nm_maddr, nm_mdata;
    logic [1:0]  nm_msize;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rv32im_lsu #(.XLEN(32), .ALLOW_MISALIGNED(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .req_i(req), .write_i(wr),
        .funct3_i(f3), .addr_i(addr), .wdata_i(wdata), .busy_o(busy), .done_o(done),
        .rdata_o(rdata), .misaligned_o(mis), .err_o(err), .mem_data_ready_o(rdy),
        .mem_clear_o(clr), .mem_addr_o(maddr), .mem_word_size_o(msize),
        .mem_write_o(mwr), .mem_data_o(mdata), .mem_data_i(mem_rdata),
        .mem_busy_i(mem_busy), .mem_err_i(mem_err)
    );

    rv32im_lsu #(.XLEN(32), .ALLOW_MISALIGNED(1'b0)) dut_nm (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(1'b0), .req_i(req_nm), .write_i(wr),
        .funct3_i(f3), .addr_i(addr), .wdata_i(wdata), .busy_o(nm_busy), .done_o(nm_done),
        .rdata_o(nm_rdata), .misaligned_o(nm_mis), .err_o(nm_err), .mem_data_ready_o(nm_rdy),
        .mem_clear_o(nm_clr), .mem_addr_o(nm_maddr), .mem_word_size_o(nm_msize),
        .mem_write_o(nm_mwr), .mem_data_o(nm_mdata), .mem_data_i(32'h0),
        .mem_busy_i(1'b0), .mem_err_i(1'b0)
    );

    // Zero-wait memory stage: busy for one cycle after the request strobe.
    logic [7:0]  s_mem [0:1023];
    logic [31:0] s_addr = '0;
    logic [31:0] s_word = '0;
    logic        s_use_word = 1'b0;
    logic        s_err_en = 1'b0;
    int          s_phase = 0;
    int          s_base;

    always @(negedge clk) begin
        if (clr) begin
            mem_err  = 1'b0;
            mem_busy = 1'b0;
            s_phase  = 0;
        end else if (s_phase == 1) begin
            mem_busy = 1'b1;
            s_phase  = 2;
        end else if (s_phase == 2) begin
            mem_busy = 1'b0;
            if (s_use_word) begin
                mem_rdata = s_word;
            end else begin
                s_base    = {22'd0, s_addr[9:2], 2'b00};
                mem_rdata = {s_mem[s_base+3], s_mem[s_base+2], s_mem[s_base+1], s_mem[s_base]};
            end
            if (s_err_en) mem_err = 1'b1;
            s_phase = 0;
        end else if (rdy) begin
            s_addr  = maddr;
            s_phase = 1;
        end
    end

    int          t_edges, t_rdy_cnt, t_clr_cnt, t_done_cnt;
    logic        t_err, t_mis, t_busy_done, t_wr0, t_size_bad;
    logic [31:0] t_rdata;
    logic [31:0] t_addr [0:3];
    logic [31:0] t_data [0:3];
    logic [1:0]  t_size0;

    // Presents one request and observes the outputs after every edge,
    // starting with the accepting edge (index 0).
    task automatic do_access(input logic w, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] d, input int flush_at, input int ncyc,
                             input bit stop_on_done);
        t_edges = -1; t_rdy_cnt = 0; t_clr_cnt = 0; t_done_cnt = 0;
        t_err = 1'b0; t_mis = 1'b0; t_busy_done = 1'b1; t_rdata = 'x;
        t_wr0 = 1'b0; t_size0 = 2'bxx; t_size_bad = 1'b0;
        for (int i = 0; i < 4; i++) begin t_addr[i] = 'x; t_data[i] = 'x; end
        wr = w; f3 = f; addr = a; wdata = d; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        for (int e = 0; e < ncyc; e++) begin
            if (e > 0) begin @(posedge clk); #1; end
            if (rdy) begin
                if (t_rdy_cnt < 4) begin t_addr[t_rdy_cnt] = maddr; t_data[t_rdy_cnt] = mdata; end
                if (t_rdy_cnt == 0) begin t_size0 = msize; t_wr0 = mwr; end
                if (t_rdy_cnt > 0 && msize != 2'b00) t_size_bad = 1'b1;
                t_rdy_cnt++;
            end
            if (clr) t_clr_cnt++;
            if (done) begin
                if (t_done_cnt == 0) begin
                    t_edges = e; t_err = err; t_mis = mis; t_rdata = rdata; t_busy_done = busy;
                end
                t_done_cnt++;
            end
            flush = (e == flush_at);
            if (done && stop_on_done) break;
        end
        flush = 1'b0;
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #2;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if ({done, mis, err, rdy, clr, mwr} !== 6'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 000000", {done, mis, err, rdy, clr, mwr}); end
        n_checks++; if ({rdata, maddr, mdata, msize} !== 98'b0) begin n_fail++; $display("FAIL reset_data: got %h/%h/%h/%b expected zeros", rdata, maddr, mdata, msize); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_byte;
        s_use_word = 1'b1; s_word = 32'h80FF_1234;
        do_access(1'b0, 3'b000, 32'h103, 32'h0, -1, 20, 1'b1);
        n_checks++; if (t_edges !== 3) begin n_fail++; $display("FAIL lb_latency: got %0d expected 3", t_edges); end
        n_checks++; if (t_rdy_cnt !== 1) begin n_fail++; $display("FAIL lb_accesses: got %0d expected 1", t_rdy_cnt); end
        n_checks++; if ({t_addr[0], t_size0} !== {32'h103, 2'b00}) begin n_fail++; $display("FAIL lb_request: got %h/%b expected 103/00", t_addr[0], t_size0); end
        n_checks++; if (t_rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_rdata: got %h expected ffffff80", t_rdata); end
        n_checks++; if ({t_err, t_busy_done} !== 2'b00) begin n_fail++; $display("FAIL lb_err_busy: got %b expected 00", {t_err, t_busy_done}); end
        do_access(1'b0, 3'b100, 32'h103, 32'h0, -1, 20, 1'b1);
        n_checks++; if (t_rdata !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_rdata: got %h expected 00000080", t_rdata); end
        do_access(1'b0, 3'b001, 32'h102, 32'h0, -1, 20, 1'b1);
        n_checks++; if (t_rdata !== 32'hFFFF_80FF) begin n_fail++; $display("FAIL lh_rdata: got %h expected ffff80ff", t_rdata); end
        do_access(1'b0, 3'b101, 32'h102, 32'h0, -1, 20, 1'b1);
        n_checks++; if (t_rdata !== 32'h0000_80FF) begin n_fail++; $display("FAIL lhu_rdata: got %h expected 000080ff", t_rdata); end
        do_access(1'b0, 3'b010, 32'h100, 32'h0, -1, 20, 1'b1);
        n_checks++; if ({t_rdata, t_size0} !== {32'h80FF_1234, 2'b10}) begin n_fail++; $display("FAIL lw_rdata: got %h/%b expected 80ff1234/10", t_rdata, t_size0); end
    endtask

    task automatic test_store_half;
        do_access(1'b1, 3'b001, 32'h102, 32'h0000_ABCD, -1, 20, 1'b1);
        n_checks++; if (t_edges !== 3) begin n_fail++; $display("FAIL sh_latency: got %0d expected 3", t_edges); end
        n_checks++; if (t_data[0] !== 32'hABCD_0000) begin n_fail++; $display("FAIL sh_data: got %h expected abcd0000", t_data[0]); end
        n_checks++; if ({t_size0, t_wr0, t_err} !== 4'b0110) begin n_fail++; $display("FAIL sh_ctrl: got %b expected 0110", {t_size0, t_wr0, t_err}); end
        n_checks++; if (t_rdata !== 32'h0) begin n_fail++; $display("FAIL sh_rdata: got %h expected 00000000", t_rdata); end
    endtask

    task automatic test_split;
        s_use_word = 1'b0;
        s_mem[32'h101] = 8'h11; s_mem[32'h102] = 8'h22; s_mem[32'h103] = 8'h33; s_mem[32'h104] = 8'h44;
        s_mem[32'h100] = 8'hAA; s_mem[32'h105] = 8'hBB; s_mem[32'h106] = 8'hCC; s_mem[32'h107] = 8'hDD;
        do_access(1'b0, 3'b010, 32'h101, 32'h0, -1, 40, 1'b1);
        n_checks++; if (t_edges !== 12) begin n_fail++; $display("FAIL lw_split_latency: got %0d expected 12", t_edges); end
        n_checks++; if (t_rdy_cnt !== 4) begin n_fail++; $display("FAIL lw_split_accesses: got %0d expected 4", t_rdy_cnt); end
        n_checks++; if ({t_addr[0], t_addr[1], t_addr[2], t_addr[3]} !== {32'h101, 32'h102, 32'h103, 32'h104}) begin
            n_fail++; $display("FAIL lw_split_addrs: got %h %h %h %h expected 101 102 103 104", t_addr[0], t_addr[1], t_addr[2], t_addr[3]); end
        n_checks++; if ({t_size0, t_size_bad} !== 3'b000) begin n_fail++; $display("FAIL lw_split_size: got %b expected 000", {t_size0, t_size_bad}); end
        n_checks++; if (t_rdata !== 32'h4433_2211) begin n_fail++; $display("FAIL lw_split_rdata: got %h expected 44332211", t_rdata); end
        do_access(1'b1, 3'b001, 32'h103, 32'h0000_BEEF, -1, 40, 1'b1);
        n_checks++; if (t_edges !== 6) begin n_fail++; $display("FAIL sh_split_latency: got %0d expected 6", t_edges); end
        n_checks++; if ({t_addr[0], t_data[0], t_addr[1], t_data[1]} !== {32'h103, 32'hEF00_0000, 32'h104, 32'h0000_00BE}) begin
            n_fail++; $display("FAIL sh_split_lanes: got %h:%h %h:%h expected 103:ef000000 104:000000be", t_addr[0], t_data[0], t_addr[1], t_data[1]); end
    endtask

    task automatic test_faults;
        int nrdy;
        int ndone;
        wr = 1'b1; f3 = 3'b010; addr = 32'h102; wdata = 32'h1234_5678; req_nm = 1'b1;
        @(posedge clk); #1;
        req_nm = 1'b0;
        n_checks++; if ({nm_done, nm_mis, nm_err, nm_busy} !== 4'b1100) begin n_fail++; $display("FAIL sw_misaligned_fault: got %b expected 1100", {nm_done, nm_mis, nm_err, nm_busy}); end
        nrdy = (nm_rdy === 1'b1) ? 1 : 0;
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (nm_rdy) nrdy++;
            if (nm_done) ndone++;
        end
        n_checks++; if ({nrdy, ndone} !== {32'd0, 32'd0}) begin n_fail++; $display("FAIL sw_misaligned_quiet: got rdy=%0d done=%0d expected 0 0", nrdy, ndone); end
        do_access(1'b0, 3'b011, 32'h100, 32'h0, -1, 6, 1'b0);
        n_checks++; if ({t_edges, t_err, t_rdy_cnt, t_done_cnt} !== {32'd0, 1'b1, 32'd0, 32'd1}) begin
            n_fail++; $display("FAIL illegal_funct3: got edge=%0d err=%b rdy=%0d done=%0d expected 0 1 0 1", t_edges, t_err, t_rdy_cnt, t_done_cnt); end
        do_access(1'b1, 3'b100, 32'h100, 32'h0, -1, 6, 1'b0);
        n_checks++; if ({t_edges, t_err, t_rdy_cnt} !== {32'd0, 1'b1, 32'd0}) begin
            n_fail++; $display("FAIL illegal_store_u: got edge=%0d err=%b rdy=%0d expected 0 1 0", t_edges, t_err, t_rdy_cnt); end
    endtask

    task automatic test_bus_error;
        s_use_word = 1'b1; s_word = 32'h0000_0080;
        do_access(1'b0, 3'b100, 32'h100, 32'h0, -1, 20, 1'b1);
        s_word = 32'hDEAD_BEEF; s_err_en = 1'b1;
        do_access(1'b0, 3'b010, 32'h200, 32'h0, -1, 8, 1'b0);
        s_err_en = 1'b0;
        n_checks++; if ({t_edges, t_err} !== {32'd3, 1'b1}) begin n_fail++; $display("FAIL buserr_done: got edge=%0d err=%b expected 3 1", t_edges, t_err); end
        n_checks++; if (t_clr_cnt !== 1) begin n_fail++; $display("FAIL buserr_clear: got %0d expected 1", t_clr_cnt); end
        n_checks++; if ({t_rdata, rdata} !== {32'h0000_0080, 32'h0000_0080}) begin n_fail++; $display("FAIL buserr_rdata: got %h/%h expected 00000080", t_rdata, rdata); end
    endtask

    task automatic test_flush;
        s_use_word = 1'b1; s_word = 32'hCAFE_F00D;
        do_access(1'b0, 3'b010, 32'h100, 32'h0, 1, 8, 1'b0);
        n_checks++; if ({t_done_cnt, t_clr_cnt} !== {32'd0, 32'd1}) begin n_fail++; $display("FAIL flush_pulses: got done=%0d clear=%0d expected 0 1", t_done_cnt, t_clr_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", busy); end
        do_access(1'b0, 3'b010, 32'h100, 32'h0, -1, 20, 1'b1);
        n_checks++; if ({t_edges, t_rdata} !== {32'd3, 32'hCAFE_F00D}) begin n_fail++; $display("FAIL flush_recover: got edge=%0d rdata=%h expected 3 cafef00d", t_edges, t_rdata); end
    endtask

    task automatic test_back_to_back;
        s_use_word = 1'b1; s_word = 32'h7F00_0000;
        do_access(1'b0, 3'b000, 32'h103, 32'h0, -1, 20, 1'b1);
        n_checks++; if (t_rdata !== 32'h0000_007F) begin n_fail++; $display("FAIL b2b_first: got %h expected 0000007f", t_rdata); end
        s_word = 32'h0000_8001;
        do_access(1'b0, 3'b001, 32'h100, 32'h0, -1, 20, 1'b1);
        n_checks++; if ({t_edges, t_rdata} !== {32'd3, 32'hFFFF_8001}) begin n_fail++; $display("FAIL b2b_second: got edge=%0d rdata=%h expected 3 ffff8001", t_edges, t_rdata); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) s_mem[i] = 8'h00;
        test_reset();
        test_load_byte();
        test_store_half();
        test_split();
        test_faults();
        test_bus_error();
        test_flush();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
